mux_arb_pkt: RTL and testbench
==============================

MUX_ARB_PKT -- requirements
Module: mux_arb_pkt

Interface
REQ-001 Parameter NUM, default 4: number of slave channels, range 2..32.
REQ-002 Parameter DSIZE, default 32: data width per channel.
REQ-003 Parameter NSIZE, default $clog2(NUM): channel-index width, derived.
REQ-004 Parameter MODE, default "FIXED": arbitration policy, "FIXED" (lowest index wins) or "RR" (round-robin).
REQ-005 Parameter PKT, default "OFF": "OFF" releases the grant after each beat; "ON" holds the grant until a beat with last=1 is accepted.
REQ-006 Port clock, input, 1: single clock; all logic on rising edge.
REQ-007 Port rst, input, 1: reset, synchronous, active-high.
REQ-008 Port s_valid, input, NUM: per-channel valid.
REQ-009 Port s_data, input, NUM*DSIZE: channel k occupies bits [k*DSIZE +: DSIZE].
REQ-010 Port s_last, input, NUM: per-channel end-of-packet flag, ignored when PKT="OFF".
REQ-011 Port s_ready, output, NUM: per-channel ready.
REQ-012 Port m_valid, output, 1: master valid, registered.
REQ-013 Port m_data, output, DSIZE: master data, registered.
REQ-014 Port m_last, output, 1: master last, registered; forced 1 when PKT="OFF".
REQ-015 Port m_sid, output, NSIZE: source channel of the current m beat, registered.
REQ-016 Port m_ready, input, 1: master ready.

Function
REQ-017 The FSM SHALL have states IDLE and LOCK; reset state is IDLE.
REQ-018 IDLE: if |s_valid, the arbiter selects channel g and registers grant<=g; next state is LOCK. Otherwise the FSM stays in IDLE.
REQ-019 FIXED: g = lowest index with s_valid=1.
REQ-020 RR: g = first index with s_valid=1, searching upward from (ptr+1) mod NUM with wrap-around. ptr is updated to g when the grant is released. ptr resets to NUM-1, so channel 0 has first priority.
REQ-021 In IDLE, all s_ready bits SHALL be 0.
REQ-022 In LOCK, s_ready[grant] = !m_valid || m_ready; all other s_ready bits SHALL be 0.
REQ-023 Beat transfer: on s_valid[grant] && s_ready[grant], the output register loads s_data[grant], s_last[grant] and grant, and sets m_valid=1 on the next edge. Latency is 1 cycle.
REQ-024 On m_valid && m_ready with no new load, m_valid clears to 0.
REQ-025 Simultaneous drain and load: the register takes the new beat and m_valid stays 1, giving full throughput within a grant.
REQ-026 m_valid && !m_ready: m_data, m_last and m_sid SHALL hold stable.
REQ-027 Release, PKT="OFF": after the first accepted beat, next state is IDLE.
REQ-028 Release, PKT="ON": after an accepted beat with s_last[grant]=1, next state is IDLE. A beat with last=0 keeps LOCK.
REQ-029 In LOCK, deassertion of s_valid[grant] SHALL NOT release the grant. Other channels' valids are ignored.
REQ-030 Each release costs one IDLE cycle, so the minimum grant-to-grant period is 2 cycles for single-beat grants.
REQ-031 A channel SHALL NOT receive ready while another channel holds the grant, so packets are never interleaved.

Reset
REQ-032 While rst=1: state=IDLE, grant=0, ptr=NUM-1, m_valid=0, m_data=0, m_last=0, m_sid=0, s_ready=0.
REQ-033 Reset asserted mid-packet or with m_valid=1 SHALL discard the buffered beat and the partial grant. There is no recovery of in-flight data.
REQ-034 The first arbitration SHALL occur in the first cycle with rst=0.

Verification (NUM=4, DSIZE=16)
REQ-035 FIXED, PKT=OFF: s_valid=4'b1010 constant, m_ready=1 -> m_sid sequence 1,1,1 (channel 3 starved); beat spacing 2 cycles.
REQ-036 RR, PKT=OFF: s_valid=4'b1111 constant, m_ready=1 -> m_sid sequence 0,1,2,3,0; m_data equals the driving channel's word each beat.
REQ-037 RR, PKT=ON: ch2 sends 3 beats (0xA0,0xA1,0xA2 with last on 0xA2) while ch0 is valid throughout -> output 0xA0,0xA1,0xA2 contiguous with m_sid=2, then ch0; s_ready[0]=0 throughout ch2's packet.
REQ-038 Backpressure: m_ready=0 for 5 cycles mid-packet -> m_data/m_sid/m_last stable, s_ready[grant]=0; on m_ready=1, throughput resumes 1 beat/cycle.
REQ-039 Reset mid-packet with m_valid=1 -> next cycle m_valid=0, s_ready=0, state IDLE; after release, arbitration restarts with ch0 highest priority.
REQ-040 Gap in s_valid[grant] for 3 cycles during a PKT=ON packet -> grant held; no other channel is serviced; the packet completes intact.

Source files
------------

// File: rtl/mux_arb_pkt.sv
// mux_arb_pkt: NUM-to-1 stream multiplexer with fixed-priority or round-robin
// arbitration, optional packet locking, and a registered single-beat output
// stage that supports full throughput within a grant.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | no grant held; arbiter picks a requester, all s_ready low
//   LOCK  | channel r_grant owns the output; only it may see s_ready
module mux_arb_pkt #(
  parameter int    NUM   = 4,
  parameter int    DSIZE = 32,
  parameter int    NSIZE = $clog2(NUM),
  parameter string MODE  = "FIXED",
  parameter string PKT   = "OFF"
) (
  input  logic                   clock,
  input  logic                   rst,
  input  logic [NUM-1:0]         s_valid,
  input  logic [NUM*DSIZE-1:0]   s_data,
  input  logic [NUM-1:0]         s_last,
  output logic [NUM-1:0]         s_ready,
  output logic                   m_valid,
  output logic [DSIZE-1:0]       m_data,
  output logic                   m_last,
  output logic [NSIZE-1:0]       m_sid,
  input  logic                   m_ready
);

  localparam bit IS_RR  = (MODE == "RR");
  localparam bit IS_PKT = (PKT == "ON");

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [NSIZE-1:0] r_grant;
  logic [NSIZE-1:0] r_ptr;

  logic             r_m_valid;
  logic [DSIZE-1:0] r_m_data;
  logic             r_m_last;
  logic [NSIZE-1:0] r_m_sid;

  logic [NSIZE-1:0] w_cand;
  logic [NSIZE-1:0] w_pick;
  logic             w_found;
  logic [DSIZE-1:0] w_sel_data;
  logic             w_sel_valid;
  logic             w_sel_last;
  logic             w_ready_g;
  logic             w_accept;
  logic             w_release;

  // Channel index reached by stepping 'off' places upward from 'base', wrapping at NUM.
  function automatic logic [NSIZE-1:0] rr_idx(input logic [NSIZE-1:0] base, input int off);
    int sum;
    sum = (int'(base) + off) % NUM;
    return NSIZE'(sum);
  endfunction

  // Arbiter: first requester in search order (upward from 0, or upward from ptr+1).
  always_comb begin
    w_cand  = '0;
    w_pick  = '0;
    w_found = 1'b0;
    for (int i = 0; i < NUM; i++) begin
      w_cand = IS_RR ? rr_idx(r_ptr, i + 1) : NSIZE'(i);
      if (!w_found && s_valid[w_cand]) begin
        w_found = 1'b1;
        w_pick  = w_cand;
      end
    end
  end

  // Select the granted channel's valid, data and last.
  always_comb begin
    w_sel_data  = '0;
    w_sel_valid = 1'b0;
    w_sel_last  = 1'b0;
    for (int k = 0; k < NUM; k++) begin
      if (r_grant == NSIZE'(k)) begin
        w_sel_data  = s_data[k*DSIZE +: DSIZE];
        w_sel_valid = s_valid[k];
        w_sel_last  = s_last[k];
      end
    end
  end

  // The output register can take a beat when it is empty or draining this cycle.
  assign w_ready_g = !r_m_valid || m_ready;
  assign w_accept  = (r_state == LOCK) && w_sel_valid && w_ready_g;

  // Ready goes only to the grant holder; held low through reset so nothing is accepted.
  always_comb begin
    s_ready = '0;
    if (!rst && (r_state == LOCK)) begin
      s_ready[r_grant] = w_ready_g;
    end
  end

  // Next-state logic: grab a grant when anyone requests, release on the closing beat.
  always_comb begin
    w_state_nxt = r_state;
    w_release   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_state_nxt = LOCK;
        end
      end
      LOCK: begin
        if (w_accept && (!IS_PKT || w_sel_last)) begin
          w_state_nxt = IDLE;
          w_release   = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State, grant and round-robin pointer registers.
  always_ff @(posedge clock) begin
    if (rst) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_ptr   <= NSIZE'(NUM - 1);
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == IDLE) && w_found) begin
        r_grant <= w_pick;
      end
      if (w_release) begin
        r_ptr <= r_grant;
      end
    end
  end

  // Output stage: load on accept, otherwise empty when the master drains it.
  always_ff @(posedge clock) begin
    if (rst) begin
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
      r_m_last  <= 1'b0;
      r_m_sid   <= '0;
    end else if (w_accept) begin
      r_m_valid <= 1'b1;
      r_m_data  <= w_sel_data;
      r_m_last  <= IS_PKT ? w_sel_last : 1'b1;
      r_m_sid   <= r_grant;
    end else if (m_ready) begin
      r_m_valid <= 1'b0;
    end
  end

  assign m_valid = r_m_valid;
  assign m_data  = r_m_data;
  assign m_last  = r_m_last;
  assign m_sid   = r_m_sid;

endmodule

// File: tb/tb_mux_arb_pkt.sv
// Bench for mux_arb_pkt: three instances (FIXED/OFF, RR/OFF, RR/ON) share the
// same stimulus; a transaction-level model predicts every output each cycle and
// logs delivered beats, which directed literal checks then pin down.
module tb_mux_arb_pkt;
  localparam int NUM = 4;
  localparam int DW  = 16;
  localparam int NI  = 3;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic              rst;
  logic              m_ready;
  logic [NUM-1:0]    s_valid;
  logic [NUM-1:0]    s_last;
  logic [NUM*DW-1:0] s_data;

  logic [NUM-1:0] sr    [NI];
  logic           mv_o  [NI];
  logic [DW-1:0]  md_o  [NI];
  logic           ml_o  [NI];
  logic [1:0]     sid_o [NI];

  mux_arb_pkt #(.NUM(NUM), .DSIZE(DW), .MODE("FIXED"), .PKT("OFF")) u_fix_off (
    .clock(clock), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
    .s_ready(sr[0]), .m_valid(mv_o[0]), .m_data(md_o[0]), .m_last(ml_o[0]),
    .m_sid(sid_o[0]), .m_ready(m_ready));

  mux_arb_pkt #(.NUM(NUM), .DSIZE(DW), .MODE("RR"), .PKT("OFF")) u_rr_off (
    .clock(clock), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
    .s_ready(sr[1]), .m_valid(mv_o[1]), .m_data(md_o[1]), .m_last(ml_o[1]),
    .m_sid(sid_o[1]), .m_ready(m_ready));

  mux_arb_pkt #(.NUM(NUM), .DSIZE(DW), .MODE("RR"), .PKT("ON")) u_rr_on (
    .clock(clock), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
    .s_ready(sr[2]), .m_valid(mv_o[2]), .m_data(md_o[2]), .m_last(ml_o[2]),
    .m_sid(sid_o[2]), .m_ready(m_ready));

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit is_rr  [NI] = '{1'b0, 1'b1, 1'b1};
  bit is_pkt [NI] = '{1'b0, 1'b0, 1'b1};
  int own [NI];     // channel holding the grant, -1 when none
  int ptr [NI];     // last channel released (round-robin origin)
  bit e_mv [NI];
  int e_md [NI];
  int e_ml [NI];
  int e_sid[NI];

  typedef struct {
    int cyc;
    int sid;
    int data;
  } beat_t;
  beat_t blog[NI][$];

  function automatic int pick(input int i, input logic [NUM-1:0] v, input int p);
    for (int off = 1; off <= NUM; off++) begin
      int c;
      c = is_rr[i] ? (p + off) % NUM : off - 1;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  always @(posedge clock) begin
    for (int i = 0; i < NI; i++) begin
      int o;
      bit acc;
      beat_t b;
      if (rst) begin
        own[i] = -1; ptr[i] = NUM - 1;
        e_mv[i] = 1'b0; e_md[i] = 0; e_ml[i] = 0; e_sid[i] = 0;
      end else begin
        o = own[i];
        if (e_mv[i] && m_ready) begin
          b.cyc = cyc; b.sid = e_sid[i]; b.data = e_md[i];
          blog[i].push_back(b);
        end
        acc = (o >= 0) && s_valid[o] && (!e_mv[i] || m_ready);
        if (acc) begin
          e_mv[i]  = 1'b1;
          e_md[i]  = int'(s_data[o*DW +: DW]);
          e_ml[i]  = is_pkt[i] ? int'(s_last[o]) : 1;
          e_sid[i] = o;
        end else if (m_ready) begin
          e_mv[i] = 1'b0;
        end
        if (o < 0) own[i] = pick(i, s_valid, ptr[i]);
        else if (acc && (!is_pkt[i] || s_last[o])) begin
          ptr[i] = o;
          own[i] = -1;
        end
      end
    end
    cyc++;
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clock) begin
    if (chk_on) begin
      for (int i = 0; i < NI; i++) begin
        int er;
        er = (!rst && own[i] >= 0 && (!e_mv[i] || m_ready)) ? (1 << own[i]) : 0;
        chk($sformatf("s_ready[%0d]", i), int'(sr[i]), er);
        chk($sformatf("m_valid[%0d]", i), int'(mv_o[i]), int'(e_mv[i]));
        chk($sformatf("m_data[%0d]", i), int'(md_o[i]), e_md[i]);
        chk($sformatf("m_last[%0d]", i), int'(ml_o[i]), e_ml[i]);
        chk($sformatf("m_sid[%0d]", i), int'(sid_o[i]), e_sid[i]);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_ch(input int ch, input logic [DW-1:0] d);
    s_data[ch*DW +: DW] = d;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) tick();
    rst = 1'b0;
  endtask

  task automatic clear_logs();
    for (int i = 0; i < NI; i++) blog[i].delete();
  endtask

  task automatic chk_beat(input string nm, input int i, input int k, input int sid, input int data);
    if (blog[i].size() <= k) chk({nm, "_present"}, blog[i].size(), k + 1);
    else begin
      chk({nm, "_sid"}, blog[i][k].sid, sid);
      chk({nm, "_data"}, blog[i][k].data, data);
    end
  endtask

  task automatic chk_gap(input string nm, input int i, input int k, input int gap);
    if (blog[i].size() <= k + 1) chk({nm, "_present"}, blog[i].size(), k + 2);
    else chk(nm, blog[i][k+1].cyc - blog[i][k].cyc, gap);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1; m_ready = 1'b1; s_valid = '0; s_last = '0; s_data = '0;
    tick();
    chk_on = 1'b1;
    tick();
    @(negedge clock);
    chk("rst_m_valid", int'(mv_o[0]), 0);
    chk("rst_s_ready", int'(sr[2]), 0);
    @(posedge clock); #1;

    // Fixed priority, 1010 constant: ch1 every 2 cycles, ch3 starved.
    rst = 1'b0;
    s_valid = 4'b1010; s_last = 4'b1111;
    for (int k = 0; k < NUM; k++) set_ch(k, 16'h0A00 + 16'(k));
    clear_logs();
    repeat (10) tick();
    chk_beat("A_fix0", 0, 0, 1, 16'h0A01);
    chk_beat("A_fix1", 0, 1, 1, 16'h0A01);
    chk_beat("A_fix2", 0, 2, 1, 16'h0A01);
    chk_gap("A_fix_gap0", 0, 0, 2);
    chk_gap("A_fix_gap1", 0, 1, 2);
    chk_beat("A_rr0", 1, 0, 1, 16'h0A01);
    chk_beat("A_rr1", 1, 1, 3, 16'h0A03);

    // Round-robin, all requesting.
    do_reset(2);
    s_valid = 4'b1111; s_last = 4'b1111;
    for (int k = 0; k < NUM; k++) set_ch(k, 16'h0B00 + 16'(k));
    clear_logs();
    repeat (12) tick();
    for (int k = 0; k < 5; k++)
      chk_beat($sformatf("B_rr%0d", k), 1, k, k % 4, 16'h0B00 + (k % 4));
    chk_beat("B_fix2", 0, 2, 0, 16'h0B00);

    // Packet lock: ch2 three-beat packet while ch0 waits.
    do_reset(2);
    s_valid = 4'b0100; s_last = 4'b0001;
    set_ch(2, 16'h00A0); set_ch(0, 16'h00C0);
    clear_logs();
    tick();
    s_valid = 4'b0101; tick();
    set_ch(2, 16'h00A1); tick();
    set_ch(2, 16'h00A2); s_last = 4'b0101; tick();
    s_valid = 4'b0001; s_last = 4'b0001;
    repeat (5) tick();
    chk_beat("C_b0", 2, 0, 2, 16'h00A0);
    chk_beat("C_b1", 2, 1, 2, 16'h00A1);
    chk_beat("C_b2", 2, 2, 2, 16'h00A2);
    chk_beat("C_b3", 2, 3, 0, 16'h00C0);
    chk_gap("C_gap0", 2, 0, 1);
    chk_gap("C_gap1", 2, 1, 1);

    // Backpressure mid-packet, then a 3-cycle valid gap, ch3 waiting.
    do_reset(2);
    m_ready = 1'b1; s_valid = 4'b0010; s_last = 4'b0000;
    set_ch(1, 16'h1B00); set_ch(3, 16'h00D3);
    clear_logs();
    tick();
    s_valid = 4'b1010; s_last = 4'b1000; tick();
    set_ch(1, 16'h1B01); tick();
    set_ch(1, 16'h1B02); m_ready = 1'b0; tick(); tick();
    @(negedge clock);
    chk("D_stall_data", int'(md_o[2]), 16'h1B01);
    chk("D_stall_sid", int'(sid_o[2]), 1);
    chk("D_stall_ready", int'(sr[2]), 0);
    @(posedge clock); #1;
    tick(); tick();
    m_ready = 1'b1; tick();
    set_ch(1, 16'h1B03); tick();
    s_valid = 4'b1000; repeat (3) tick();
    s_valid = 4'b1010; set_ch(1, 16'h1B04); s_last = 4'b1010; tick();
    s_valid = 4'b1000; s_last = 4'b1000;
    repeat (4) tick();
    for (int k = 0; k < 5; k++)
      chk_beat($sformatf("D_b%0d", k), 2, k, 1, 16'h1B00 + k);
    chk_beat("D_b5", 2, 5, 3, 16'h00D3);
    chk_gap("D_resume0", 2, 1, 1);
    chk_gap("D_resume1", 2, 2, 1);

    // Reset with a buffered beat mid-packet.
    do_reset(2);
    s_valid = 4'b0100; s_last = 4'b0000; set_ch(2, 16'h00E0);
    tick(); tick();
    rst = 1'b1;
    @(negedge clock);
    chk("E_pre_m_valid", int'(mv_o[2]), 1);
    @(posedge clock); #1;
    rst = 1'b0;
    s_valid = 4'b1111; s_last = 4'b1111;
    for (int k = 0; k < NUM; k++) set_ch(k, 16'h0E00 + 16'(k));
    clear_logs();
    @(negedge clock);
    chk("E_post_m_valid", int'(mv_o[2]), 0);
    chk("E_post_s_ready", int'(sr[2]), 0);
    @(posedge clock); #1;
    repeat (6) tick();
    chk_beat("E_rr_off", 1, 0, 0, 16'h0E00);
    chk_beat("E_rr_on", 2, 0, 0, 16'h0E00);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
